day_2_range_parser: RTL and testbench
=====================================

# day_2_range_parser

Upstream stage of the Day 2 solver. Consumes the raw puzzle input as an ASCII byte stream (`lo-hi,lo-hi,...`), converts the decimal text to 64-bit unsigned range pairs, and delivers them through a small FIFO to the range-checking stage. The pairs it produces replace the preloaded `table_1`/`table_2` memory images as the source of ranges.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `COUNT_W`, 16: width of `range_count`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` holds a valid byte.
- `in_ready` out 1: the parser accepts a byte this cycle.
- `in_data` in 8: ASCII input byte.
- `in_last` in 1: the current byte is the final byte of the input; qualified by `in_valid`.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: downstream pops the head when `out_valid` is high.
- `out_lo` out 64: range start.
- `out_hi` out 64: range end.
- `range_count` out `COUNT_W`: number of ranges pushed so far; saturates at its maximum.
- `err` out 1: sticky malformed-input flag.
- `done` out 1: input fully consumed and FIFO drained.

## Operation
- **Byte accepted:** the cycle where `in_valid && in_ready`.
- **`in_ready`:** high only in `LO` or `HI` with the FIFO not full.
- **States:**
  - `LO`: accumulating the start value.
  - `HI`: accumulating the end value.
  - `FLUSH`: waiting for the FIFO to empty.
  - `DONE`: terminal until `rst`.
- **Accumulator:** 64-bit `acc` plus a `seen_digit` bit; both clear on every state change.
- **Digit `0`–`9`:** `acc <= acc*10 + (c-8'h30)`, computed modulo 2^64; sets `seen_digit`.
- **`-`:**
  - In `LO` with `seen_digit`: `lo_reg <= acc`, go to `HI`.
  - Otherwise: set `err`, byte dropped.
- **`,` or LF:**
  - In `HI` with `seen_digit`: push `{lo_reg, acc}`, increment `range_count`, go to `LO`.
  - In `LO` without `seen_digit`: ignored, so blank or trailing separators are legal.
  - Otherwise: set `err`, discard the partial value, go to `LO`.
- **CR and space:** ignored.
- **Any other byte:** set `err`, ignored.
- **`in_last`:**
  - The byte is processed first.
  - If the state is then still `HI` with `seen_digit`, the pair is pushed as if a `,` followed.
  - Any other unterminated partial value sets `err`.
  - Next state is `FLUSH`.
- **At most one push per accepted byte.**
- **`FLUSH`:** go to `DONE` when the FIFO is empty.
- **`DONE`:** `done = 1`, `in_ready = 0`.

## Timing
- **Throughput:** one byte per cycle when unstalled.
- **Push-to-`out_valid`:** 1 cycle (registered FIFO). `out_lo`/`out_hi` are stable while `out_valid && !out_ready`.
- **FIFO full:** `in_ready` deasserts in the same cycle via combinational full. Push and pop are never both blocked. A pop while full frees a slot for the next cycle only.
- **Empty FIFO:** `out_valid = 0`; `out_lo`/`out_hi` hold their last value.
- **`done`:** asserts the cycle after the FIFO becomes empty in `FLUSH`.
- **Reset values:**
  - State `LO`, FIFO empty, `acc = 0`, `lo_reg = 0`.
  - `in_ready = 1`, `out_valid = 0`, `out_lo = 0`, `out_hi = 0`.
  - `range_count = 0`, `err = 0`, `done = 0`.
- **Reset mid-stream:** discards all partial values and FIFO contents; the next accepted byte starts a fresh parse.

## Configuration
- **`DAY2_RANGE_CHECK_EN` defined:**
  - A digit that would overflow 2^64 − 1 sets `err`.
  - A pair with `lo > hi` sets `err` and is not pushed, and `range_count` is unchanged.
- **Undefined:** no checks; wrapped values and inverted pairs are pushed as-is.

## Structure
- **Package `day2_pkg`:**
  - `range_t` packed struct `{lo[63:0], hi[63:0]}`.
  - Character constants `CH_0`, `CH_9`, `CH_DASH`, `CH_COMMA`, `CH_LF`, `CH_CR`, `CH_SP`.
  - Parser state enum.
- **Sub-module `range_fifo`:** synchronous `range_t` FIFO with `FIFO_DEPTH` entries, wrap-around pointers and an extra pointer bit for full/empty. Parser FSM and accumulator stay in the top level.

## Test plan
- **Basic stream:** `11-22,95-115\n` with `in_last` on LF, `out_ready = 1` → pairs (11,22) then (95,115); `range_count = 2`, `err = 0`, `done` high.
- **Backpressure:** 5 ranges `1-2,3-4,5-6,7-8,9-10` with `out_ready = 0` → `in_ready` low after the 4th push; raising `out_ready` drains all 5 in order.
- **Implicit terminator:** `7-9` with `in_last` on `9` → one pair (7,9); `done` after the pop.
- **Large and malformed values:**
  - `9999999999-10000000010,` → (9999999999, 10000000010).
  - `12x-3,` → `err = 1`, pair (12,3) still pushed when the macro is off.
- **Macro on:**
  - `30-20,` → `err = 1`, no push.
  - A 21-digit value → `err = 1`.
- **Reset mid-stream:** assert `rst` after `123-4` → outputs at reset values; `5-6,` then yields only (5,6).

Source files
------------

// File: rtl/day_2_range_parser_pkg.sv
// Shared types and character constants for the Day 2 range parser.
package day2_pkg;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
  } range_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;

  typedef enum logic [1:0] {
    ST_LO    = 2'd0,
    ST_HI    = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/day_2_range_parser_range_fifo.sv
// Synchronous range_t FIFO; the head holds its last popped value while empty.
module range_fifo
  import day2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  range_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output range_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  range_t      last_q, last_d;
  range_t      mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/day_2_range_parser.sv
// ASCII "lo-hi,..." stream to 64-bit range pairs through a small FIFO.
// Optional DAY2_RANGE_CHECK_EN adds overflow and lo>hi checking.
//
// state | meaning
// LO    | accumulating the start value
// HI    | accumulating the end value
// FLUSH | input finished, waiting for the FIFO to drain
// DONE  | terminal until rst
module day_2_range_parser
  import day2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_lo,
  output logic [63:0]        out_hi,
  output logic [COUNT_W-1:0] range_count,
  output logic               err,
  output logic               done
);

  state_e             state_q, state_d;
  logic [63:0]        acc_q, acc_d;
  logic               seen_q, seen_d;
  logic [63:0]        lo_q, lo_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic        accept;
  logic        try_push, push;
  logic [63:0] pair_hi;
  logic        fifo_full, fifo_empty;
  range_t      fifo_head, push_data;
  logic [63:0] acc_next_digit;
`ifdef DAY2_RANGE_CHECK_EN
  logic [67:0] acc_wide;
  logic        acc_ovf;
`endif

  assign in_ready = ((state_q == ST_LO) || (state_q == ST_HI)) && !fifo_full;
  assign accept   = in_valid && in_ready;

  // Digits 0-9 carry their value in the low nibble of the ASCII code.
`ifdef DAY2_RANGE_CHECK_EN
  assign acc_wide       = {4'b0, acc_q} * 68'd10 + {64'b0, in_data[3:0]};
  assign acc_next_digit = acc_wide[63:0];
  assign acc_ovf        = |acc_wide[67:64];
`else
  assign acc_next_digit = (acc_q << 3) + (acc_q << 1) + {60'b0, in_data[3:0]};
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    seen_d   = seen_q;
    lo_d     = lo_q;
    err_d    = err_q;
    count_d  = count_q;
    try_push = 1'b0;
    push     = 1'b0;
    pair_hi  = acc_q;

    if (state_q == ST_FLUSH && fifo_empty) state_d = ST_DONE;

    if (accept) begin
      if (is_digit(in_data)) begin
        acc_d  = acc_next_digit;
        seen_d = 1'b1;
`ifdef DAY2_RANGE_CHECK_EN
        if (acc_ovf) err_d = 1'b1;
`endif
      end else if (in_data == CH_DASH) begin
        if (state_q == ST_LO && seen_q) begin
          lo_d    = acc_q;
          state_d = ST_HI;
          acc_d   = '0;
          seen_d  = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else if (in_data == CH_COMMA || in_data == CH_LF) begin
        if (state_q == ST_HI && seen_q) begin
          pair_hi  = acc_q;
          try_push = 1'b1;
          state_d  = ST_LO;
          acc_d    = '0;
          seen_d   = 1'b0;
        end else if (!(state_q == ST_LO && !seen_q)) begin
          err_d   = 1'b1;
          state_d = ST_LO;
          acc_d   = '0;
          seen_d  = 1'b0;
        end
      end else if (in_data != CH_CR && in_data != CH_SP) begin
        err_d = 1'b1;
      end

      // A separator push and an implicit end-of-input push are exclusive:
      // a separator always leaves the parser in LO.
      if (in_last) begin
        if (state_d == ST_HI && seen_d) begin
          pair_hi  = acc_d;
          try_push = 1'b1;
        end else if (state_d == ST_HI || seen_d) begin
          err_d = 1'b1;
        end
        state_d = ST_FLUSH;
        acc_d   = '0;
        seen_d  = 1'b0;
      end
    end

`ifdef DAY2_RANGE_CHECK_EN
    if (try_push && (lo_q > pair_hi)) err_d = 1'b1;
    else                              push  = try_push;
`else
    push = try_push;
`endif

    if (push && count_q != {COUNT_W{1'b1}}) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LO;
      acc_q   <= '0;
      seen_q  <= 1'b0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      seen_q  <= seen_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign push_data = '{lo: lo_q, hi: pair_hi};

  range_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign out_valid   = !fifo_empty;
  assign out_lo      = fifo_head.lo;
  assign out_hi      = fifo_head.hi;
  assign range_count = count_q;
  assign err         = err_q;
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_day_2_range_parser.sv
// Scoreboard bench for day_2_range_parser: expected pairs queued at stimulus, popped by a monitor.
module tb_day_2_range_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_lo;
  logic [63:0] out_hi;
  logic [15:0] range_count;
  logic        err;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  day_2_range_parser #(
    .FIFO_DEPTH (4),
    .COUNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_lo      (out_lo),
    .out_hi      (out_hi),
    .range_count (range_count),
    .err         (err),
    .done        (done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop is compared against the oldest expected pair.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got lo=%0d hi=%0d expected none", out_lo, out_hi);
      end else begin
        check("pop_pair", {out_lo, out_hi}, exp_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] dec(input string s);
    logic [63:0] r = '0;
    for (int i = 0; i < s.len(); i++) r = r * 64'd10 + 64'(s[i] - 8'h30);
    return r;
  endfunction

  task automatic expect_pair(input logic [63:0] lo, input logic [63:0] hi);
    exp_q.push_back({lo, hi});
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_rst_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_rst_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_rst_out_pair"}, {out_lo, out_hi}, 128'd0);
    check({tag, "_rst_count"}, 128'(range_count), 128'd0);
    check({tag, "_rst_err_done"}, {126'd0, err, done}, 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] c, input logic last);
    int  n = 0;
    logic ok;
    in_valid = 1'b1;
    in_data  = c;
    in_last  = last;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 300);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic send_str(input string s, input logic last_on_final);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 128'(done), 128'd1);
    check({tag, "_fifo_drained"}, 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input int cnt, input logic e);
    @(negedge clk);
    check({tag, "_count"}, 128'(range_count), 128'(cnt));
    check({tag, "_err"}, 128'(err), 128'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    do_reset();
    check_reset_values("init");

    // Basic stream, in_last on the LF
    expect_pair(64'd11, 64'd22);
    expect_pair(64'd95, 64'd115);
    send_str("11-22,95-115\n", 1'b1);
    wait_done("basic");
    check_status("basic", 2, 1'b0);

    // Backpressure: FIFO fills after the 4th push
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i += 2) expect_pair(64'(i), 64'(i + 1));
    send_str("1-2,3-4,5-6,7-8,", 1'b0);
    @(negedge clk);
    check("bp_in_ready_full", 128'(in_ready), 128'd0);
    check("bp_out_valid", 128'(out_valid), 128'd1);
    check("bp_head_stable", {out_lo, out_hi}, {64'd1, 64'd2});
    @(posedge clk);
    #1;
    fork
      send_str("9-10", 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_done("bp");
    check_status("bp", 5, 1'b0);

    // Implicit terminator on the final digit
    do_reset();
    expect_pair(64'd7, 64'd9);
    send_str("7-9", 1'b1);
    wait_done("implicit");
    check_status("implicit", 1, 1'b0);

    // Values above 32 bits
    do_reset();
    expect_pair(64'd9999999999, 64'd10000000010);
    send_str("9999999999-10000000010,", 1'b1);
    wait_done("large");
    check_status("large", 1, 1'b0);

    // Stray letter sets err; pair is inverted so the check build drops it
    do_reset();
`ifdef DAY2_RANGE_CHECK_EN
    send_str("12x-3,", 1'b1);
    wait_done("malformed");
    check_status("malformed", 0, 1'b1);
`else
    expect_pair(64'd12, 64'd3);
    send_str("12x-3,", 1'b1);
    wait_done("malformed");
    check_status("malformed", 1, 1'b1);
`endif

    // Inverted pair
    do_reset();
`ifdef DAY2_RANGE_CHECK_EN
    send_str("30-20,", 1'b1);
    wait_done("inverted");
    check_status("inverted", 0, 1'b1);
`else
    expect_pair(64'd30, 64'd20);
    send_str("30-20,", 1'b1);
    wait_done("inverted");
    check_status("inverted", 1, 1'b0);
`endif

    // 21-digit start value wraps past 2^64-1
    do_reset();
`ifdef DAY2_RANGE_CHECK_EN
    send_str("123456789012345678901-1,", 1'b1);
    wait_done("overflow");
    check_status("overflow", 0, 1'b1);
`else
    expect_pair(dec("123456789012345678901"), 64'd1);
    send_str("123456789012345678901-1,", 1'b1);
    wait_done("overflow");
    check_status("overflow", 1, 1'b0);
`endif

    // Blank separators, CR and spaces are ignored; dash in HI is an error
    do_reset();
    expect_pair(64'd4, 64'd5);
    send_str(",\n4 - 5\r\n,", 1'b1);
    wait_done("blank");
    check_status("blank", 1, 1'b0);
    do_reset();
    expect_pair(64'd4, 64'd5);
    send_str("4-5-", 1'b0);
    send_str(",", 1'b1);
    wait_done("dash_hi");
    check_status("dash_hi", 1, 1'b1);

    // Unterminated partial value at end of input
    do_reset();
    send_str("8-", 1'b1);
    wait_done("partial");
    check_status("partial", 0, 1'b1);

    // Reset mid-stream
    do_reset();
    send_str("123-4", 1'b0);
    do_reset();
    check_reset_values("mid");
    expect_pair(64'd5, 64'd6);
    send_str("5-6,", 1'b1);
    wait_done("mid");
    check_status("mid", 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
